// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and sizing helpers for the UART transmitter
package uart_pkg;

    localparam int DEFAULT_CPU_CLOCK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD_RATE      = 115200;
    localparam int UART_FRAME_BITS        = 10;   // start + 8 data + stop

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Core clock cycles per transmitted bit
    function automatic int symbol_edge_time(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Width of a counter that runs 0..set-1; never narrower than one bit
    function automatic int baud_cnt_width(input int set);
        return (set > 1) ? $clog2(set) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    // Status comes straight from the registered count, so a same-cycle pop never frees room
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer and count update; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; clearing the count flushes the FIFO on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter with full/idle/overflow status
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CPU_CLOCK_FREQ = DEFAULT_CPU_CLOCK_FREQ,
    parameter int BAUD_RATE      = DEFAULT_BAUD_RATE,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    input  logic       ovf_clr,
    output logic       tx_full,
    output logic       tx_idle,
    output logic       tx_ovf,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CPU_CLOCK_FREQ, BAUD_RATE);
    localparam int CW               = baud_cnt_width(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] BAUD_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_FRAME_BITS - 3);

    tx_state_e   state_q,    state_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q,  bit_idx_d;
    logic [7:0]  shift_q,    shift_d;
    logic        ovf_q,      ovf_d;
    logic        serial_q,   serial_d;

    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        baud_end;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_wr),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign baud_end   = (baud_cnt_q == BAUD_LAST);
    assign tx_full    = fifo_full;
    assign tx_idle    = (state_q == ST_IDLE) && fifo_empty;
    assign tx_ovf     = ovf_q;
    assign serial_out = serial_q;

    // Frame sequencer: pops a byte, walks start/data/stop one bit period each, chains frames
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit so back-to-back frames have no gap
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the current state one cycle later; sticky overflow with set winning over clear
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift_q[0];
            default:  serial_d = 1'b1;
        endcase
        ovf_d = (tx_wr && fifo_full) || (ovf_q && !ovf_clr);
    end

    // State registers; reset drives the line high immediately and aborts any frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ovf_q      <= 1'b0;
            serial_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ovf_q      <= ovf_d;
            serial_q   <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a line receiver and scoreboard
module tb_uart_tx_fifo;

    localparam int SET   = 50_000_000 / 115200;   // 434 cycles per bit
    localparam int FRAME = 10 * SET;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_full, tx_idle, tx_ovf, serial_out;

    uart_tx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data),
        .ovf_clr    (ovf_clr),
        .tx_full    (tx_full),
        .tx_idle    (tx_idle),
        .tx_ovf     (tx_ovf),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         rx_frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line receiver: samples mid-bit, checks framing, compares bytes against the scoreboard
    logic       rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = 8'h00;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (serial_out === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % SET == SET / 2) begin
                int k;
                k = rx_cnt / SET;
                if (k == 0) begin
                    chk("rx_start_bit", 32'(serial_out), 32'd0);
                end else if (k <= 8) begin
                    rx_byte[k-1] = serial_out;
                end else begin
                    chk("rx_stop_bit", 32'(serial_out), 32'd1);
                    rx_busy = 1'b0;
                    rx_frames++;
                    if (exp_q.size() == 0) chk("rx_unexpected_frame", 32'd0, 32'd1);
                    else chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_rx(input int target, input int budget, input string name);
        int k = 0;
        while (rx_frames < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(rx_frames), 32'(target));
    endtask

    // Consecutive writes starting at a negedge; n0 is the edge that took the first byte
    task automatic burst(input logic [7:0] b[$], input bit push_exp, output int n0);
        n0 = 0;
        for (int i = 0; i < b.size(); i++) begin
            tx_wr   = 1'b1;
            tx_data = b[i];
            if (push_exp) exp_q.push_back(b[i]);
            @(negedge clk);
            if (i == 0) n0 = cyc;
        end
        tx_wr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_serial_out"}, 32'(serial_out), 32'd1);
        chk({tag, "_tx_full"},    32'(tx_full),    32'd0);
        chk({tag, "_tx_idle"},    32'(tx_idle),    32'd1);
        chk({tag, "_tx_ovf"},     32'(tx_ovf),     32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       acc;
        logic       full;
        logic       ovf;
    } wr_vec_t;

    wr_vec_t    tbl[6];
    logic [7:0] loop_bytes[3];

    initial begin
        int n, base;
        logic [7:0] bq[$];

        tbl[0] = '{8'h41, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h42, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h43, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h44, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h45, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h46, 1'b0, 1'b1, 1'b1};
        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'hA5;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("por");

        // Single frame latency and bit timing
        bq = '{8'h55};
        burst(bq, 1'b1, n);
        chk("t2_busy_after_write", 32'(tx_idle), 32'd0);
        wait_until(n + 1);
        chk("t2_line_high_n1", 32'(serial_out), 32'd1);
        wait_until(n + 2);
        chk("t2_line_low_n2", 32'(serial_out), 32'd0);
        wait_until(n + 2 + SET - 1);
        chk("t2_start_last_cycle", 32'(serial_out), 32'd0);
        wait_until(n + 2 + SET);
        chk("t2_bit0_first_cycle", 32'(serial_out), 32'd1);
        wait_until(n + 2 + 2 * SET);
        chk("t2_bit1_first_cycle", 32'(serial_out), 32'd0);
        wait_until(n + 2 + FRAME - 1);
        chk("t2_stop_bit", 32'(serial_out), 32'd1);
        wait_until(n + 2 + FRAME);
        chk("t2_idle_after_frame", 32'(tx_idle), 32'd1);
        wait_rx(1, 100, "t2_frames");
        if (start_q.size() > 0) chk("t2_start_time", 32'(start_q[0]), 32'(n + 2));
        else chk("t2_start_seen", 32'd0, 32'd1);
        start_q.delete();

        // Burst into a full FIFO: table of status after each write edge
        base = rx_frames;
        for (int i = 0; i < 6; i++) begin
            tx_wr   = 1'b1;
            tx_data = tbl[i].data;
            if (tbl[i].acc) exp_q.push_back(tbl[i].data);
            @(negedge clk);
            if (i == 0) n = cyc;
            chk($sformatf("t3_full_w%0d", i), 32'(tx_full), 32'(tbl[i].full));
            chk($sformatf("t3_ovf_w%0d", i),  32'(tx_ovf),  32'(tbl[i].ovf));
        end
        tx_wr = 1'b0;
        wait_rx(base + 5, 5 * FRAME + 1000, "t3_frames");
        chk("t3_frame_count", 32'(start_q.size()), 32'd5);
        if (start_q.size() == 5) begin
            chk("t3_first_start", 32'(start_q[0]), 32'(n + 2));
            for (int i = 1; i < 5; i++)
                chk($sformatf("t3_gap_%0d", i), 32'(start_q[i] - start_q[i-1]), 32'(FRAME));
        end
        wait_until(start_q[0] + 5 * FRAME);
        chk("t3_idle_after_burst", 32'(tx_idle), 32'd1);
        chk("t3_ovf_sticky", 32'(tx_ovf), 32'd1);
        start_q.delete();

        // Overflow clear, then clear racing a dropped write
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", 32'(tx_ovf), 32'd0);
        bq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        burst(bq, 1'b1, n);
        chk("t4_full", 32'(tx_full), 32'd1);
        tx_wr   = 1'b1;
        tx_data = 8'h66;
        ovf_clr = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
        ovf_clr = 1'b0;
        chk("t4_set_wins", 32'(tx_ovf), 32'd1);

        // Asynchronous reset mid-cycle while busy, full and overflowed
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        start_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Reset during a data bit with bytes queued, then one clean frame
        bq = '{8'hA5, 8'h11, 8'h22};
        burst(bq, 1'b0, n);
        wait_until(n + 1 + 4 * SET + 200);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t5_rst");
        start_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_line_quiet", 32'(serial_out), 32'd1);
        chk("t5_fifo_flushed", 32'(tx_idle), 32'd1);
        base = rx_frames;
        bq = '{8'h3C};
        burst(bq, 1'b1, n);
        wait_rx(base + 1, FRAME + 100, "t5_frame");
        repeat (FRAME + 100) @(negedge clk);
        chk("t5_no_stale_frames", 32'(rx_frames), 32'(base + 1));
        chk("t5_idle", 32'(tx_idle), 32'd1);

        // Loopback of boundary byte values
        base = rx_frames;
        bq = {};
        for (int i = 0; i < 3; i++) bq.push_back(loop_bytes[i]);
        burst(bq, 1'b1, n);
        wait_rx(base + 3, 3 * FRAME + 1000, "t6_frames");
        chk("t6_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
